// File: rtl/pwm_timer.sv
// pwm_timer: prescaled period counter with shadowed period/compare registers,
// per-channel registered PWM outputs, an end-of-period tick and one-shot mode.
module pwm_timer #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned CHANNELS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en_i,
  input  logic                      one_shot_i,
  input  logic                      start_i,
  input  logic [WIDTH-1:0]          prescaler_i,
  input  logic [WIDTH-1:0]          period_i,
  input  logic [CHANNELS*WIDTH-1:0] compare_i,
  output logic [CHANNELS-1:0]       pwm_out_o,
  output logic                      tick_o,
  output logic [WIDTH-1:0]          count_o,
  output logic                      busy_o
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]                state_q,   state_d;
  logic [WIDTH-1:0]          psc_cnt_q, psc_cnt_d;
  logic [WIDTH-1:0]          count_q,   count_d;
  logic [WIDTH-1:0]          p_sh_q,    p_sh_d;
  logic [WIDTH-1:0]          n_sh_q,    n_sh_d;
  logic [CHANNELS*WIDTH-1:0] c_sh_q,    c_sh_d;
  logic                      mode_sh_q, mode_sh_d;
  logic                      tick_q,    tick_d;
  logic [CHANNELS-1:0]       pwm_q,     pwm_d;
  logic                      psc_tick_c;

  // Prescaler clock enable: one count step every P_sh+1 cycles while running.
  assign psc_tick_c = (state_q == RUN) && (psc_cnt_q == p_sh_q);

  // Next-state, counter, shadow and output logic.
  always_comb begin
    state_d   = state_q;
    psc_cnt_d = psc_cnt_q;
    count_d   = count_q;
    p_sh_d    = p_sh_q;
    n_sh_d    = n_sh_q;
    c_sh_d    = c_sh_q;
    mode_sh_d = mode_sh_q;
    tick_d    = 1'b0;
    pwm_d     = '0;

    case (state_q)
      IDLE: begin
        if (en_i && (!one_shot_i || start_i)) begin
          state_d   = RUN;
          p_sh_d    = prescaler_i;
          n_sh_d    = period_i;
          c_sh_d    = compare_i;
          mode_sh_d = one_shot_i;
          psc_cnt_d = '0;
          count_d   = '0;
        end
      end

      RUN: begin
        if (!en_i) begin
          // Abort: no tick, outputs and counters cleared at this edge.
          state_d   = IDLE;
          psc_cnt_d = '0;
          count_d   = '0;
        end else begin
          for (int i = 0; i < int'(CHANNELS); i++) begin
            pwm_d[i] = (count_q < c_sh_q[i*WIDTH +: WIDTH]);
          end
          if (psc_tick_c) begin
            psc_cnt_d = '0;
            if (count_q == n_sh_q) begin
              // Period end: wrap, pulse tick, take new settings for next period.
              count_d = '0;
              tick_d  = 1'b1;
              p_sh_d  = prescaler_i;
              n_sh_d  = period_i;
              c_sh_d  = compare_i;
              if (mode_sh_q) begin
                state_d = IDLE;
              end
            end else begin
              count_d = count_q + WIDTH'(1);
            end
          end else begin
            psc_cnt_d = psc_cnt_q + WIDTH'(1);
          end
        end
      end

      default: begin
        state_d   = IDLE;
        psc_cnt_d = '0;
        count_d   = '0;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      psc_cnt_q <= '0;
      count_q   <= '0;
      p_sh_q    <= '0;
      n_sh_q    <= '0;
      c_sh_q    <= '0;
      mode_sh_q <= 1'b0;
      tick_q    <= 1'b0;
      pwm_q     <= '0;
    end else begin
      state_q   <= state_d;
      psc_cnt_q <= psc_cnt_d;
      count_q   <= count_d;
      p_sh_q    <= p_sh_d;
      n_sh_q    <= n_sh_d;
      c_sh_q    <= c_sh_d;
      mode_sh_q <= mode_sh_d;
      tick_q    <= tick_d;
      pwm_q     <= pwm_d;
    end
  end

  assign pwm_out_o = pwm_q;
  assign tick_o    = tick_q;
  assign count_o   = count_q;
  assign busy_o    = (state_q == RUN);

endmodule

// File: tb/tb_pwm_timer.sv
// Bench for pwm_timer: elapsed-cycle reference model compared every cycle,
// directed scenarios with literal expectations, then randomized runs.
module tb_pwm_timer;

  localparam int unsigned W  = 8;
  localparam int unsigned CH = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            en = 1'b0;
  logic            one_shot = 1'b0;
  logic            start = 1'b0;
  logic [W-1:0]    prescaler = '0;
  logic [W-1:0]    period = '0;
  logic [CH*W-1:0] compare = '0;
  logic [CH-1:0]   pwm_out;
  logic            tick;
  logic [W-1:0]    count;
  logic            busy;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_on = 1'b0;

  pwm_timer #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clk(clk), .rst_n(rst_n), .en_i(en), .one_shot_i(one_shot), .start_i(start),
    .prescaler_i(prescaler), .period_i(period), .compare_i(compare),
    .pwm_out_o(pwm_out), .tick_o(tick), .count_o(count), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: k = clk cycles elapsed in the current period.
  // count = k / (P+1); period ends when k reaches (P+1)*(N+1).
  bit          m_run = 0;
  bit          m_mode = 0;
  longint      m_k = 0;
  longint      m_p = 0;
  longint      m_n = 0;
  longint      m_c [CH];
  bit          e_tick = 0;
  bit [CH-1:0] e_pwm = '0;

  task automatic load_shadows();
    m_p = prescaler;
    m_n = period;
    for (int i = 0; i < CH; i++) m_c[i] = compare[i*W +: W];
  endtask

  initial for (int i = 0; i < CH; i++) m_c[i] = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 0; m_mode = 0; m_k = 0; m_p = 0; m_n = 0;
      for (int i = 0; i < CH; i++) m_c[i] = 0;
      e_tick = 0; e_pwm = '0;
    end else if (!m_run) begin
      e_tick = 0; e_pwm = '0;
      if (en && (!one_shot || start)) begin
        m_run = 1; m_mode = one_shot; m_k = 0;
        load_shadows();
      end
    end else if (!en) begin
      m_run = 0; m_k = 0; e_tick = 0; e_pwm = '0;
    end else begin
      for (int i = 0; i < CH; i++) e_pwm[i] = ((m_k / (m_p + 1)) < m_c[i]);
      m_k++;
      if (m_k == (m_p + 1) * (m_n + 1)) begin
        e_tick = 1; m_k = 0;
        load_shadows();
        if (m_mode) m_run = 0;
      end else begin
        e_tick = 0;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("tick", tick, e_tick);
      chk("busy", busy, m_run);
      chk("count", count, m_k / (m_p + 1));
      chk("pwm_out", pwm_out, e_pwm);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tick(input string name, input int max, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick && n < max);
    if (!tick) chk({name, "_timeout"}, n, -1);
  endtask

  task automatic set_cfg(input int p, input int n, input int c0, input int c1,
                         input int c2, input int c3, input bit os);
    prescaler = W'(p);
    period    = W'(n);
    compare   = {W'(c3), W'(c2), W'(c1), W'(c0)};
    one_shot  = os;
  endtask

  initial begin
    int n;
    int hi [CH];
    int tk, bz, tnb;
    int exp_cnt [6];
    int exp_tk [6];

    // Reset state
    #3;
    chk("rst_tick", tick, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", count, 0);
    chk("rst_pwm", pwm_out, 0);
    cyc(2);
    rst_n = 1'b1;
    cmp_on = 1'b1;
    cyc(2);

    // Basic continuous count, P=0 N=3
    set_cfg(0, 3, 0, 0, 0, 0, 0);
    en = 1'b1;
    exp_cnt = '{0, 1, 2, 3, 0, 1};
    exp_tk  = '{0, 0, 0, 0, 1, 0};
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      chk("basic_count", count, exp_cnt[j]);
      chk("basic_tick", tick, exp_tk[j]);
    end
    en = 1'b0;
    cyc(2);

    // Duty cycles P=1 N=4 C={2,0,5,7}
    set_cfg(1, 4, 2, 0, 5, 7, 0);
    en = 1'b1;
    cyc(11);
    for (int i = 0; i < CH; i++) hi[i] = 0;
    tk = 0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      for (int i = 0; i < CH; i++) hi[i] += int'(pwm_out[i]);
      tk += int'(tick);
    end
    chk("duty_ch0", hi[0], 4);
    chk("duty_ch1", hi[1], 0);
    chk("duty_ch2", hi[2], 10);
    chk("duty_ch3", hi[3], 10);
    chk("duty_ticks", tk, 1);
    wait_tick("duty_align", 20, n);
    wait_tick("duty_interval", 20, n);
    chk("duty_interval", n, 10);
    en = 1'b0;
    cyc(2);

    // Mid-period period change does not affect current period
    set_cfg(0, 3, 0, 0, 0, 0, 0);
    en = 1'b1;
    cyc(2);
    chk("shadow_count1", count, 1);
    period = W'(7);
    wait_tick("shadow_end", 20, n);
    chk("shadow_end", n, 3);
    wait_tick("shadow_next", 20, n);
    chk("shadow_next", n, 8);
    en = 1'b0;
    cyc(2);

    // One-shot, P=2 N=1, second start while busy ignored
    set_cfg(2, 1, 1, 0, 0, 0, 1);
    en = 1'b1;
    start = 1'b1;
    bz = 0; tk = 0; tnb = 0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      bz  += int'(busy);
      tk  += int'(tick);
      tnb += int'(tick && !busy);
      start = (j == 3);
    end
    chk("oneshot_busy", bz, 6);
    chk("oneshot_ticks", tk, 1);
    chk("oneshot_tick_busy_low", tnb, 1);
    en = 1'b0;
    cyc(2);

    // en dropped mid-period, then restart with fresh shadows
    set_cfg(0, 5, 4, 0, 0, 0, 0);
    en = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (count != W'(2) && n < 20);
    chk("abort_reach2", count, 2);
    chk("abort_pwm_before", pwm_out, 1);
    en = 1'b0;
    @(negedge clk);
    chk("abort_count", count, 0);
    chk("abort_busy", busy, 0);
    chk("abort_pwm", pwm_out, 0);
    chk("abort_tick", tick, 0);
    period = W'(2);
    en = 1'b1;
    @(negedge clk);
    chk("restart_count0", count, 0);
    exp_cnt = '{1, 2, 0, 1, 2, 0};
    exp_tk  = '{0, 0, 1, 0, 0, 1};
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("restart_count", count, exp_cnt[j]);
      chk("restart_tick", tick, exp_tk[j]);
    end
    en = 1'b0;
    cyc(2);

    // Asynchronous reset mid-period
    set_cfg(1, 3, 3, 3, 3, 3, 0);
    en = 1'b1;
    cyc(5);
    #2 rst_n = 1'b0;
    #1;
    chk("async_tick", tick, 0);
    chk("async_busy", busy, 0);
    chk("async_count", count, 0);
    chk("async_pwm", pwm_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", busy, 1);
    chk("post_rst_count", count, 0);
    cyc(2);
    chk("post_rst_count1", count, 1);
    en = 1'b0;
    cyc(2);

    // All-ones terminal values
    set_cfg(0, 255, 255, 128, 0, 1, 0);
    en = 1'b1;
    cyc(300);
    en = 1'b0;
    cyc(2);
    set_cfg(255, 1, 1, 2, 0, 255, 0);
    en = 1'b1;
    cyc(530);
    en = 1'b0;
    cyc(2);

    // Randomized operation against the model
    for (int s = 0; s < 40; s++) begin
      int p, nn;
      p  = int'($urandom_range(0, 3));
      nn = int'($urandom_range(0, 7));
      set_cfg(p, nn, int'($urandom_range(0, nn + 2)), int'($urandom_range(0, nn + 2)),
              int'($urandom_range(0, nn + 2)), int'($urandom_range(0, nn + 2)),
              1'($urandom_range(0, 1)));
      en = 1'b1;
      start = 1'($urandom_range(0, 1));
      for (int j = 0; j < int'($urandom_range(30, 80)); j++) begin
        @(negedge clk);
        en = ($urandom_range(0, 99) >= 5);
        start = ($urandom_range(0, 99) < 10);
        if ($urandom_range(0, 99) < 5) one_shot = ~one_shot;
        if ($urandom_range(0, 99) < 10) begin
          nn = int'($urandom_range(0, 7));
          set_cfg(int'($urandom_range(0, 3)), nn, int'($urandom_range(0, nn + 2)),
                  int'($urandom_range(0, nn + 2)), int'($urandom_range(0, nn + 2)),
                  int'($urandom_range(0, nn + 2)), one_shot);
        end
      end
    end
    en = 1'b0;
    cyc(3);

    cmp_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
